// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register file constants and types for decode and writeback.
package regfile_pkg;
    localparam int REG_WIDTH = 32;
    localparam int REG_DEPTH = 32;
    localparam int REG_IDXW = $clog2(REG_DEPTH);
    typedef logic [REG_IDXW-1:0] reg_idx_t;
    typedef logic [REG_WIDTH-1:0] reg_data_t;
    localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with flush/write-clear/reserve priority.
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int DEPTH = REG_DEPTH,
    parameter int NREAD = 2,
    parameter int NWRITE = 1,
    parameter int ZERO_REG = 1,
    localparam int IDXW = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NWRITE-1:0]              wr_en,
    input  logic [NWRITE-1:0][IDXW-1:0]    wr_idx,
    input  logic                           rsv_en,
    input  logic [IDXW-1:0]                rsv_idx,
    input  logic                           flush,
    input  logic [NREAD-1:0][IDXW-1:0]     rd_idx,
    output logic [NREAD-1:0]               rd_busy
);
    localparam logic [IDXW:0] DEPTH_W = (IDXW+1)'(DEPTH);
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    function automatic logic in_range(input logic [IDXW-1:0] idx);
        return {1'b0, idx} < DEPTH_W;
    endfunction
    // Reserve is applied last so the newest owner keeps the register busy.
    always_comb begin
        w_busy_nxt = flush ? '0 : r_busy;
        for (int p = 0; p < NWRITE; p++)
            if (wr_en[p] && in_range(wr_idx[p])) w_busy_nxt[wr_idx[p]] = 1'b0;
        if (rsv_en && in_range(rsv_idx)) w_busy_nxt[rsv_idx] = 1'b1;
        if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) r_busy <= '0;
        else r_busy <= w_busy_nxt;
    always_comb begin
        rd_busy = '0;
        for (int r = 0; r < NREAD; r++)
            rd_busy[r] = in_range(rd_idx[r]) && r_busy[rd_idx[r]];
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass, busy scoreboard
// and optional registered read outputs.
module regfile_mp import regfile_pkg::*; #(
    parameter int WIDTH = REG_WIDTH,
    parameter int DEPTH = REG_DEPTH,
    parameter int NREAD = 2,
    parameter int NWRITE = 1,
    parameter int ZERO_REG = 1,
    parameter int READ_REG = 0,
    localparam int IDXW = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NWRITE-1:0]              wr_en,
    input  logic [NWRITE-1:0][IDXW-1:0]    wr_idx,
    input  logic [NWRITE-1:0][WIDTH-1:0]   wr_data,
    input  logic [NREAD-1:0][IDXW-1:0]     rd_idx,
    output logic [NREAD-1:0][WIDTH-1:0]    rd_data,
    output logic [NREAD-1:0]               rd_busy,
    input  logic                           rsv_en,
    input  logic [IDXW-1:0]                rsv_idx,
    input  logic                           flush
);
    localparam logic [IDXW:0] DEPTH_W = (IDXW+1)'(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [NREAD-1:0][WIDTH-1:0] w_rd_data;
    logic [NREAD-1:0] w_rd_busy;
    logic [NREAD-1:0] w_sb_busy;
    logic [NREAD-1:0] w_hit;
    function automatic logic in_range(input logic [IDXW-1:0] idx);
        return {1'b0, idx} < DEPTH_W;
    endfunction
    function automatic logic is_zero(input logic [IDXW-1:0] idx);
        return (ZERO_REG != 0) && (idx == IDXW'(REG_ZERO));
    endfunction
    regfile_scoreboard #(
        .DEPTH(DEPTH), .NREAD(NREAD), .NWRITE(NWRITE), .ZERO_REG(ZERO_REG)
    ) u_sb (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx),
        .rsv_en(rsv_en), .rsv_idx(rsv_idx), .flush(flush),
        .rd_idx(rd_idx), .rd_busy(w_sb_busy)
    );
    // Later ports are evaluated last, so the highest-numbered port wins a collision.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int p = 0; p < NWRITE; p++)
                if (wr_en[p] && in_range(wr_idx[p]) && !is_zero(wr_idx[p]))
                    r_mem[wr_idx[p]] <= wr_data[p];
        end
    always_comb begin
        w_rd_data = '0;
        w_hit = '0;
        for (int r = 0; r < NREAD; r++) begin
            w_rd_data[r] = r_mem[rd_idx[r]];
            for (int p = 0; p < NWRITE; p++)
                if (wr_en[p] && wr_idx[p] == rd_idx[r]) begin
                    w_rd_data[r] = wr_data[p];
                    w_hit[r] = 1'b1;
                end
            if (!in_range(rd_idx[r]) || is_zero(rd_idx[r])) w_rd_data[r] = '0;
        end
    end
    assign w_rd_busy = w_sb_busy & ~w_hit;
    if (READ_REG != 0) begin : g_rd_reg
        logic [NREAD-1:0][WIDTH-1:0] r_rd_data;
        logic [NREAD-1:0] r_rd_busy;
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                r_rd_data <= '0;
                r_rd_busy <= '0;
            end else begin
                r_rd_data <= w_rd_data;
                r_rd_busy <= w_rd_busy;
            end
        assign rd_data = r_rd_data;
        assign rd_busy = r_rd_busy;
    end else begin : g_rd_comb
        assign rd_data = w_rd_data;
        assign rd_busy = w_rd_busy;
    end
endmodule
